// File: rtl/iob2axi_rd_pkg.sv
// iob2axi_rd_pkg: shared AXI4 widths and encodings used by the native-to-AXI read bridge
package iob2axi_rd_pkg;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_ID_W    = 1;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;
  localparam int AXI_RESP_W  = 2;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR   = 2'd1;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MODIFY = 4'd2;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT_NSEC    = 3'd2;
endpackage

// File: rtl/iob2axi_rd.sv
// iob2axi_rd: native burst read request to single AXI4 INCR read burst
// Ports: clk/rst (async, active-high); length/ready/error burst control;
//   s_valid/s_addr/s_rdata/s_ready native side; m_axi_ar*/m_axi_r* AXI4 read master.
// Optional: define IOB2AXI_RD_RLAST_CHK_EN to flag misplaced or missing RLAST as an error.
module iob2axi_rd
  import iob2axi_rd_pkg::*;
#(
  parameter int ADDR_W = 0,
  parameter int DATA_W = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXI_LEN_W-1:0]   length,
  output logic                   ready,
  output logic                   error,
  input  logic                   s_valid,
  input  logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_rdata,
  output logic                   s_ready,
  output logic [AXI_ID_W-1:0]    m_axi_arid,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [AXI_LEN_W-1:0]   m_axi_arlen,
  output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
  output logic [AXI_BURST_W-1:0] m_axi_arburst,
  output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
  output logic [AXI_CACHE_W-1:0] m_axi_arcache,
  output logic [AXI_PROT_W-1:0]  m_axi_arprot,
  output logic [AXI_QOS_W-1:0]   m_axi_arqos,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [AXI_ID_W-1:0]    m_axi_rid,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);
  typedef enum logic [1:0] {IDLE, ADDR_HS, READ} state_t;
  state_t                r_state;
  logic                  r_ready;
  logic                  r_error;
  logic                  r_arvalid;
  logic [ADDR_W-1:0]     r_addr;
  logic [AXI_LEN_W-1:0]  r_len;
  logic [AXI_LEN_W:0]    r_cnt;
  logic                  w_read;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_beat_err;
  logic                  w_unused;
  assign w_read = r_state == READ;
  assign w_beat = w_read & m_axi_rvalid & s_valid;
  assign w_last = r_cnt == {1'b0, r_len};
`ifdef IOB2AXI_RD_RLAST_CHK_EN
  // RLAST must coincide exactly with the counter-defined final beat
  assign w_beat_err = (|m_axi_rresp) | (m_axi_rlast != w_last);
  assign w_unused   = ^m_axi_rid;
`else
  assign w_beat_err = |m_axi_rresp;
  assign w_unused   = ^{m_axi_rid, m_axi_rlast};
`endif
  assign ready         = r_ready;
  assign error         = r_error;
  assign s_rdata       = m_axi_rdata;
  assign s_ready       = w_read & m_axi_rvalid;
  assign m_axi_rready  = w_read & s_valid;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = AXI_SIZE_W'($clog2(DATA_W / 8));
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = '0;
  assign m_axi_arcache = AXI_CACHE_MODIFY;
  assign m_axi_arprot  = AXI_PROT_NSEC;
  assign m_axi_arqos   = '0;
  assign m_axi_arvalid = r_arvalid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_error   <= 1'b0;
      r_arvalid <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
    end else
      case (r_state)
        IDLE:
          if (s_valid) begin
            r_state   <= ADDR_HS;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
            r_arvalid <= 1'b1;
            r_addr    <= s_addr;
            r_len     <= length;
            r_cnt     <= '0;
          end
        ADDR_HS:
          if (m_axi_arready) begin
            r_state   <= READ;
            r_arvalid <= 1'b0;
          end
        READ:
          if (w_beat) begin
            r_cnt   <= r_cnt + 1'b1;
            r_error <= r_error | w_beat_err;
            if (w_last) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end
        default: begin
          r_state   <= IDLE;
          r_ready   <= 1'b1;
          r_arvalid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_iob2axi_rd.sv
// tb_iob2axi_rd: scoreboard bench for iob2axi_rd with an in-line AXI read slave model
module tb_iob2axi_rd;
  import iob2axi_rd_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  logic                   clk;
  logic                   rst;
  logic [AXI_LEN_W-1:0]   length;
  logic                   ready;
  logic                   error;
  logic                   s_valid;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_rdata;
  logic                   s_ready;
  logic [AXI_ID_W-1:0]    arid;
  logic [AW-1:0]          araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic [AXI_LOCK_W-1:0]  arlock;
  logic [AXI_CACHE_W-1:0] arcache;
  logic [AXI_PROT_W-1:0]  arprot;
  logic [AXI_QOS_W-1:0]   arqos;
  logic                   arvalid;
  logic                   arready;
  logic [AXI_ID_W-1:0]    rid;
  logic [DW-1:0]          rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;
  logic [DW-1:0]          sb_q[$];
  int                     n_cmp;
  int                     n_err;
  iob2axi_rd #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .length(length), .ready(ready), .error(error),
    .s_valid(s_valid), .s_addr(s_addr), .s_rdata(s_rdata), .s_ready(s_ready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int ar_dly,
                           input int err_b, input int last_b, input int stall_b,
                           input int stall_n, input int rst_b);
    logic          exp_err;
    logic [DW-1:0] d;
    exp_err = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_addr  = addr;
    length  = AXI_LEN_W'(len);
    #1 check("idle_ready", ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_addr  = '1;
    length  = '1;
    #1;
    check("busy_ready", ready, 0);
    check("err_clear", error, 0);
    check("arvalid", arvalid, 1);
    check("araddr", araddr, addr);
    check("arlen", arlen, len);
    check("arburst", arburst, 1);
    check("arsize", arsize, 2);
    check("arcache", arcache, 2);
    check("arprot", arprot, 2);
    check("arid_lock_qos", {arid, arlock, arqos}, 0);
    for (int i = 0; i < ar_dly; i++) begin
      arready = 1'b0;
      rvalid  = 1'b1;
      s_valid = 1'b1;
      #1;
      check("ar_hold", arvalid, 1);
      check("ar_no_rready", rready, 0);
      check("ar_no_sready", s_ready, 0);
      @(negedge clk);
    end
    rvalid  = 1'b0;
    s_valid = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1 check("ar_drop", arvalid, 0);
    for (int b = 0; b <= len; b++) begin
      d = {addr[15:0], 16'(b)} ^ 32'h5a5a_0000;
      if (b == rst_b) begin
        s_valid = 1'b1;
        rvalid  = 1'b1;
        rdata   = d;
        rst     = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_rready", rready, 0);
        check("rst_sready", s_ready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        rvalid  = 1'b0;
        sb_q.delete();
        return;
      end
      if (b == stall_b)
        for (int k = 0; k < stall_n; k++) begin
          s_valid = 1'b0;
          rvalid  = 1'b1;
          rdata   = d;
          #1;
          check("stall_rready", rready, 0);
          check("stall_sready", s_ready, 1);
          check("stall_data", s_rdata, d);
          @(negedge clk);
        end
      s_valid = 1'b1;
      rvalid  = 1'b1;
      rdata   = d;
      rresp   = (b == err_b) ? 2'd2 : 2'd0;
      rlast   = (b == len) || (b == last_b);
      sb_q.push_back(d);
      if (rresp != 0) exp_err = 1'b1;
`ifdef IOB2AXI_RD_RLAST_CHK_EN
      if (rlast != (b == len)) exp_err = 1'b1;
`endif
      #1;
      check("beat_rready", rready, 1);
      if (s_ready && s_valid) check("rdata", s_rdata, sb_q.pop_front());
      else check("beat_sready", s_ready, 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = '0;
    #1;
    check("done_ready", ready, 1);
    check("done_error", error, exp_err);
    check("done_rready", rready, 0);
    check("beats_left", sb_q.size(), 0);
  endtask
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    length  = '0;
    s_valid = 1'b0;
    s_addr  = '0;
    arready = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_error", error, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_sready", s_ready, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    @(negedge clk);
    rst = 1'b0;
    run_burst(32'h100, 3, 0, -1, -1, -1, 0, -1);
    run_burst(32'h200, 1, 5, -1, -1, -1, 0, -1);
    run_burst(32'h300, 3, 0, 2, -1, -1, 0, -1);
    run_burst(32'h400, 3, 0, -1, -1, 1, 3, -1);
    run_burst(32'h500, 3, 0, -1, -1, -1, 0, 1);
    run_burst(32'h600, 0, 0, -1, -1, -1, 0, -1);
    run_burst(32'h700, 2, 0, -1, 1, -1, 0, -1);
    run_burst(32'h800, 7, 2, 7, -1, 4, 2, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/iob2axi_rd.md
IOB2AXI_RD -- requirements
Module: iob2axi_rd

Interface
REQ-001 SHALL have parameter ADDR_W, default 0, native/AXI address width (instantiator sets it).
REQ-002 SHALL have parameter DATA_W, default 0, native/AXI data width, multiple of 8 (instantiator sets it).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port length  input  AXI_LEN_W  burst beats minus one, sampled at burst start.
REQ-006 SHALL have port ready  output  1  high = idle, new burst accepted.
REQ-007 SHALL have port error  output  1  sticky RRESP error of last/current burst.
REQ-008 SHALL have port s_valid  input  1  native request/beat-accept strobe.
REQ-009 SHALL have port s_addr  input  ADDR_W  burst start byte address.
REQ-010 SHALL have port s_rdata  output  DATA_W  read beat data, equal to m_axi_rdata.
REQ-011 SHALL have port s_ready  output  1  beat valid on native side.
REQ-012 SHALL have AR outputs m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid, input m_axi_arready, widths from the shared AXI header.
REQ-013 SHALL have R inputs m_axi_rid/rdata/rresp/rlast/rvalid, output m_axi_rready, widths from the shared AXI header.

Function
REQ-014 SHALL implement states IDLE, ADDR_HS, READ; default/illegal state returns to IDLE.
REQ-015 In IDLE, SHALL drive ready=1; on s_valid=1, register s_addr and length, clear error, zero beat counter, go to ADDR_HS (ready=0 next cycle).
REQ-016 In ADDR_HS, SHALL hold registered arvalid=1 until the cycle arvalid&arready, then go to READ with arvalid=0 next cycle.
REQ-017 SHALL drive araddr=addr_reg, arlen=length_reg, arsize=clog2(DATA_W/8), arburst=1 (INCR), arcache=2, arprot=2, arid=0, arlock=0, arqos=0.
REQ-018 In READ, SHALL drive rready=s_valid and s_ready=rvalid combinationally; beat completes when rvalid&s_valid.
REQ-019 On each completed beat, SHALL increment counter (width AXI_LEN_W+1) and set error if rresp!=0; error never clears mid-burst.
REQ-020 On completed beat with counter==length_reg, SHALL go to IDLE; ready=1 the following cycle.
REQ-021 s_valid low mid-burst SHALL stall (rready=0), no beat lost; length/s_addr changes after burst start SHALL be ignored.
REQ-022 Outside READ, rready and s_ready SHALL be 0.

Reset
REQ-023 On rst, SHALL immediately force state IDLE, ready=1, error=0, arvalid=0, rready=0, s_ready=0, counter=0, addr_reg=0, length_reg=0; reset mid-burst abandons the burst.

Configuration
REQ-024 With IOB2AXI_RD_RLAST_CHK_EN defined, SHALL set error when rlast on a beat other than counter==length_reg or missing on the final beat; end of burst remains counter-based.
REQ-025 Without IOB2AXI_RD_RLAST_CHK_EN, m_axi_rlast SHALL be ignored.

Structure
REQ-026 AXI width constants (AXI_LEN_W, AXI_ID_W, AXI_RESP_W, etc.) and burst/cache/prot encodings SHALL come from the shared AXI header; state encodings local.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 Reset, then s_valid with s_addr=0x100, length=3 -> arvalid next cycle, araddr=0x100, arlen=3, arburst=1; 4 beats delivered, ready=1 after 4th, error=0.
REQ-029 arready held low 5 cycles -> arvalid stays 1 all 5 cycles, no R activity accepted.
REQ-030 Beat 2 of 4 with rresp=2 -> error=1 at end, cleared at next burst start.
REQ-031 s_valid dropped 3 cycles mid-burst with rvalid=1 -> rready=0, data held, beat count exact.
REQ-032 rst asserted in READ after beat 1 -> same-cycle ready=1, rready=0; next burst length=0 completes in 1 beat.
REQ-033 RLAST_CHK_EN defined, rlast on beat 1 of length=2 -> error=1; undefined -> error=0.
